// File: rtl/program_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package program_loader_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] COUNT_MAX = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: synchroniser, start-bit glitch filter, mid-bit sampler.
module program_loader_uart_rx
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [2:0]    sync_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;
    logic          fall_s;

    // sync_q[2] is the previous synchronised sample, so a start needs a real falling edge
    assign rx_s   = sync_q[1];
    assign fall_s = !sync_q[1] && sync_q[2];

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: begin
                if (fall_s) state_d = RX_START;
                else        state_d = RX_IDLE;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) state_d = rx_s ? RX_IDLE : RX_DATA;
                else                    state_d = RX_START;
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST && bit_q == 3'd7) state_d = RX_STOP;
                else                                    state_d = RX_DATA;
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) state_d = RX_IDLE;
                else                   state_d = RX_STOP;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Counter, shifter and result next-values.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) cnt_d = '0;
                else                    cnt_d = cnt_q + CW'(1);
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    ferr_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx_i};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image over UART, writes it into instruction memory
// and holds the core in reset until the checksum is confirmed.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5_000_000,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data,
    output logic                  mem_wren,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    logic        bv_s, fe_s, good_s, active_s, tmo_hit_s, bad_s, err_entry_s;
    logic [7:0]  bd_s;

    ld_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  crst_q, crst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            sum_q, sum_d;
    logic [1:0]            idx_q, idx_d;
    logic [6:0]            words_q, words_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    program_loader_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock        (clock),
        .reset        (reset),
        .rx_i         (uart_rx),
        .byte_valid_o (bv_s),
        .byte_data_o  (bd_s),
        .frame_err_o  (fe_s)
    );

    assign good_s      = bv_s && !fe_s;
    assign active_s    = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign tmo_hit_s   = active_s && !bv_s && (tmo_q == TMO_LAST);
    assign bad_s       = (bv_s && fe_s) || tmo_hit_s;
    assign err_entry_s = (state_d == ST_ERROR) && (state_q != ST_ERROR);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (good_s && bd_s == HDR_BYTE) state_d = ST_COUNT;
                else                            state_d = state_q;
            end
            ST_COUNT: begin
                if (bad_s)       state_d = ST_ERROR;
                else if (good_s) state_d = (bd_s > COUNT_MAX) ? ST_ERROR : ST_DATA;
                else             state_d = ST_COUNT;
            end
            ST_DATA: begin
                // leave only once the last word's strobe has actually been issued
                if (bad_s)                          state_d = ST_ERROR;
                else if (wren_q && words_q == 7'd0) state_d = ST_CHECK;
                else                                state_d = ST_DATA;
            end
            ST_CHECK: begin
                if (bad_s)       state_d = ST_ERROR;
                else if (good_s) state_d = (bd_s == sum_q) ? ST_DONE : ST_ERROR;
                else             state_d = ST_CHECK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-values.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        crst_d  = crst_q;
        done_d  = done_q;
        err_d   = err_q | err_entry_s;
        sum_d   = sum_q;
        idx_d   = idx_q;
        words_d = words_q;
        if (bv_s)                                tmo_d = '0;
        else if (active_s && tmo_q != TMO_LAST)  tmo_d = tmo_q + TW'(1);
        else                                     tmo_d = tmo_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (state_d == ST_COUNT) begin
                    crst_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    addr_d = '0;
                    sum_d  = 8'h00;
                    idx_d  = 2'd0;
                end else begin
                    crst_d = crst_q;
                end
            end
            ST_COUNT: begin
                if (state_d == ST_DATA) words_d = bd_s[6:0];
                else                    words_d = words_q;
            end
            ST_DATA: begin
                if (good_s) begin
                    data_d[{idx_q, 3'b000} +: 8] = bd_s;
                    sum_d  = sum8(sum_q, bd_s);
                    idx_d  = idx_q + 2'd1;
                    wren_d = (idx_q == 2'd3);
                end else if (wren_q && words_q != 7'd0) begin
                    // the last word keeps its address, so a 128-word frame ends at 127
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    words_d = words_q - 7'd1;
                end else begin
                    wren_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (state_d == ST_DONE) begin
                    crst_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    done_d = done_q;
                end
            end
            default: wren_d = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= 32'h0000_0000;
            wren_q  <= 1'b0;
            crst_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= 8'h00;
            idx_q   <= 2'd0;
            words_q <= 7'd0;
            tmo_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            crst_q  <= crst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = wren_q;
    assign core_reset  = crst_q;
    assign load_done   = done_q;
    assign load_error  = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives UART frames and checks memory writes and status.
module tb_program_loader;

    localparam int CPB = 8;
    localparam int TMO = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic [6:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    logic [6:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        wr_crst_q[$];
    int          wren_double = 0;
    logic        wren_prev   = 1'b0;

    program_loader #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO),
        .ADDR_WIDTH   (7)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .core_reset  (core_reset),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clock = ~clock;

    // Log every write strobe; flag any strobe longer than one cycle.
    always @(negedge clock) begin
        if (mem_wren) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_data);
            wr_crst_q.push_back(core_reset);
        end
        if (mem_wren && wren_prev) wren_double <= wren_double + 1;
        wren_prev <= mem_wren;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(!bad_stop);
        uart_rx = 1'b1;
        tick(2);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_crst_q.delete();
    endtask

    // EF+BE+AD+DE = 0x338, so the valid checksum is 0x38.
    task automatic send_one_word(input logic [7:0] chk);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(chk, 1'b0);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        checks++; if (mem_address !== 7'd0) begin failures++; $display("FAIL reset_addr got %h exp 0", mem_address); end
        checks++; if (mem_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", mem_data); end
        checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got %b exp 0", mem_wren); end
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL reset_core_reset got %b exp 0", core_reset); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", load_done); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL reset_error got %b exp 0", load_error); end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_one_word();
        clear_log();
        send_byte(8'hA5, 1'b0);
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL one_hdr_core_reset got %b exp 1", core_reset); end
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h38, 1'b0);
        checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL one_wr_count got %0d exp 1", wr_addr_q.size()); end
        else begin
            checks++; if (wr_addr_q[0] !== 7'd0) begin failures++; $display("FAIL one_wr_addr got %h exp 0", wr_addr_q[0]); end
            checks++; if (wr_data_q[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL one_wr_data got %h exp deadbeef", wr_data_q[0]); end
            checks++; if (wr_crst_q[0] !== 1'b1) begin failures++; $display("FAIL one_wr_core_reset got %b exp 1", wr_crst_q[0]); end
        end
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL one_core_reset got %b exp 0", core_reset); end
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL one_done got %b exp 1", load_done); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL one_error got %b exp 0", load_error); end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        send_one_word(8'h39);
        checks++; if (wr_addr_q.size() != 1) begin failures++; $display("FAIL badchk_wr_count got %0d exp 1", wr_addr_q.size()); end
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL badchk_error got %b exp 1", load_error); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL badchk_done got %b exp 0", load_done); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL badchk_core_reset got %b exp 1", core_reset); end
        send_one_word(8'h38);
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL recover_error got %b exp 0", load_error); end
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL recover_done got %b exp 1", load_done); end
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL recover_core_reset got %b exp 0", core_reset); end
    endtask

    task automatic test_full_load();
        logic [31:0] exp_w;
        clear_log();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h7F, 1'b0);
        for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b0);
        // sum of 0..255 twice is 0xFF00, so the checksum is 0x00
        send_byte(8'h00, 1'b0);
        checks++; if (wr_addr_q.size() != 128) begin failures++; $display("FAIL full_wr_count got %0d exp 128", wr_addr_q.size()); end
        else begin
            for (int w = 0; w < 128; w++) begin
                exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
                checks++; if (wr_addr_q[w] !== 7'(w)) begin failures++; $display("FAIL full_addr[%0d] got %h exp %h", w, wr_addr_q[w], 7'(w)); end
                checks++; if (wr_data_q[w] !== exp_w) begin failures++; $display("FAIL full_data[%0d] got %h exp %h", w, wr_data_q[w], exp_w); end
            end
            checks++; if (wr_data_q[127] !== 32'hFFFEFDFC) begin failures++; $display("FAIL full_last_word got %h exp fffefdfc", wr_data_q[127]); end
        end
        checks++; if (mem_address !== 7'd127) begin failures++; $display("FAIL full_final_addr got %h exp 7f", mem_address); end
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL full_done got %b exp 1", load_done); end
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL full_core_reset got %b exp 0", core_reset); end
        checks++; if (wren_double != 0) begin failures++; $display("FAIL wren_width got %0d long strobes exp 0", wren_double); end
    endtask

    task automatic test_framing_error();
        clear_log();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b1);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL ferr_error got %b exp 1", load_error); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL ferr_core_reset got %b exp 1", core_reset); end
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h38, 1'b0);
        checks++; if (wr_addr_q.size() != 0) begin failures++; $display("FAIL ferr_wr_count got %0d exp 0", wr_addr_q.size()); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL ferr_done got %b exp 0", load_done); end
        send_byte(8'hA5, 1'b0);
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL count80_hdr_error got %b exp 0", load_error); end
        send_byte(8'h80, 1'b0);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL count80_error got %b exp 1", load_error); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL count80_core_reset got %b exp 1", core_reset); end
    endtask

    task automatic test_timeout_glitch();
        clear_log();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        tick(50);
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL tmo_early_error got %b exp 0", load_error); end
        tick(100);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL tmo_error got %b exp 1", load_error); end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(5);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h38, 1'b0);
        checks++; if (wr_data_q.size() != 1) begin failures++; $display("FAIL glitch_wr_count got %0d exp 1", wr_data_q.size()); end
        else begin
            checks++; if (wr_data_q[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL glitch_wr_data got %h exp deadbeef", wr_data_q[0]); end
        end
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL glitch_done got %b exp 1", load_done); end
    endtask

    task automatic test_async_reset();
        clear_log();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        uart_rx = 1'b0;
        tick(20);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL arst_core_reset got %b exp 0", core_reset); end
        checks++; if (mem_data !== 32'h0) begin failures++; $display("FAIL arst_data got %h exp 0", mem_data); end
        checks++; if (mem_address !== 7'd0) begin failures++; $display("FAIL arst_addr got %h exp 0", mem_address); end
        checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL arst_wren got %b exp 0", mem_wren); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL arst_done got %b exp 0", load_done); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL arst_error got %b exp 0", load_error); end
        uart_rx = 1'b1;
        tick(20);
        reset = 1'b1;
        tick(4);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL post_rst_core_reset got %b exp 0", core_reset); end
        checks++; if (wr_addr_q.size() != 0) begin failures++; $display("FAIL post_rst_wr_count got %0d exp 0", wr_addr_q.size()); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL post_rst_error got %b exp 0", load_error); end
        send_one_word(8'h38);
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL post_rst_done got %b exp 1", load_done); end
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_bad_checksum();
        test_full_load();
        test_framing_error();
        test_timeout_glitch();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
